// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory behind a MOV/MOC four-phase handshake.
// Define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  typeData,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        ALIGN_ERR
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t state, state_n;

    logic [3:0]        cnt, cnt_n;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;

    logic [7:0] mem [0:(2**ADDR_W)-1];

    logic capture, fire, release_ack;
    logic is_byte, is_half, is_word;
    logic bad, we;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0] rdata;

    logic unused_addr;
    assign unused_addr = ^Address[31:ADDR_W];

    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);
    assign is_word = size_q[1];

    // Byte offsets wrap naturally at the ADDR_W boundary
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

`ifdef MEM_ALIGN_CHECK_EN
    assign bad = (is_half && addr_q[0]) ||
                 (is_word && (addr_q[1:0] != 2'b00));
`else
    assign bad = 1'b0;
`endif

    assign we = fire && !rw_q && !bad;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        capture     = 1'b0;
        fire        = 1'b0;
        release_ack = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (MOV) begin
                    capture = 1'b1;
                    cnt_n   = 4'(WAIT_STATES);
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    fire    = 1'b1;
                    state_n = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!MOV) begin
                    release_ack = 1'b1;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        unique case (1'b1)
            is_byte: rdata = {24'h0, mem[a0]};
            is_half: rdata = {16'h0, mem[a0], mem[a1]};
            is_word: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            rw_q   <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            din_q  <= 32'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                rw_q   <= RW;
                size_q <= typeData;
                addr_q <= Address[ADDR_W-1:0];
                din_q  <= DataIn;
            end
        end
    end

    // Storage is never reset; a reset in WAIT leaves state IDLE so we stays low
    always_ff @(posedge CLK) begin
        if (we) begin
            unique case (1'b1)
                is_byte: mem[a0] <= din_q[7:0];
                is_half: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                is_word: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            MOC     <= 1'b0;
            DataOut <= 32'h0;
        end else if (fire) begin
            MOC <= 1'b1;
            if (bad) begin
                DataOut <= 32'h0;
            end else if (rw_q) begin
                DataOut <= rdata;
            end
        end else if (release_ack) begin
            MOC <= 1'b0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ALIGN_ERR <= 1'b0;
        end else if (fire) begin
            ALIGN_ERR <= bad;
        end else if (release_ack) begin
            ALIGN_ERR <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests, monitor on MOC rise.
// Covers both builds of MEM_ALIGN_CHECK_EN.
module tb_mem_responder;

    localparam int WS = 2;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        MOV = 1'b0;
    logic        RW = 1'b0;
    logic [1:0]  typeData = 2'b00;
    logic [31:0] Address = 32'h0;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut;
    logic        MOC;
    logic        align_act;

    int compared = 0;
    int mismatched = 0;
    logic [32:0] exp_q[$];
    logic moc_prev = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    logic ALIGN_ERR;
    assign align_act = ALIGN_ERR;
`else
    assign align_act = 1'b0;
`endif

    mem_responder #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .MOV      (MOV),
        .RW       (RW),
        .typeData (typeData),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MOC      (MOC)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .ALIGN_ERR(ALIGN_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every MOC rise consumes one expected {ALIGN_ERR, DataOut}
    always @(negedge CLK) begin
        if (MOC && !moc_prev) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_moc: got %h expected none",
                         DataOut);
            end else begin
                chk("moc_resp", {align_act, DataOut}, exp_q.pop_front());
            end
        end
        moc_prev = MOC;
    end

    task automatic req(input logic rw, input logic [1:0] td,
                       input logic [31:0] addr, input logic [31:0] din,
                       input logic [31:0] exp_do, input logic exp_al,
                       input bit drop_early, input string name);
        int n;
        bit seen;
        @(negedge CLK);
        MOV = 1'b1;
        RW = rw;
        typeData = td;
        Address = addr;
        DataIn = din;
        exp_q.push_back({exp_al, exp_do});
        @(posedge CLK);
        #1;
        RW = ~rw;
        typeData = ~td;
        Address = ~addr;
        DataIn = ~din;
        if (drop_early) MOV = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
            if (MOC) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no MOC expected MOC", name);
        end else begin
            chk({name, "_lat"}, 33'(n), 33'(WS + 1));
        end
        if (!drop_early) begin
            @(negedge CLK);
            MOV = 1'b0;
        end
        @(posedge CLK);
        #1;
        chk({name, "_fall"}, {align_act, 31'h0, MOC}, 33'h0);
    endtask

    initial begin : stim
        bit moc_seen;
        for (int i = 0; i < 256; i++) dut.mem[i] = 8'h00;
        dut.mem[0] = 8'hDE;
        dut.mem[1] = 8'hAD;
        dut.mem[2] = 8'hBE;
        dut.mem[3] = 8'hEF;
        repeat (2) @(negedge CLK);
        chk("reset_out", {align_act, DataOut}, 33'h0);
        chk("reset_moc", {32'h0, MOC}, 33'h0);
        CLR = 1'b0;

        req(1'b1, 2'b10, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd_w0");
        req(1'b1, 2'b00, 32'hFFFF_FF02, 32'h0, 32'h000000BE, 1'b0, 1'b0,
            "rd_b2");
        req(1'b1, 2'b01, 32'h2, 32'h0, 32'h0000BEEF, 1'b0, 1'b0, "rd_h2");
        req(1'b0, 2'b01, 32'h4, 32'h12345678, 32'h0000BEEF, 1'b0, 1'b0,
            "wr_h4");
        chk("mem4", 33'(dut.mem[4]), 33'h56);
        chk("mem5", 33'(dut.mem[5]), 33'h78);
        chk("mem6", 33'(dut.mem[6]), 33'h00);
        chk("mem7", 33'(dut.mem[7]), 33'h00);
        req(1'b1, 2'b10, 32'h4, 32'h0, 32'h56780000, 1'b0, 1'b0, "rd_w4");

`ifndef MEM_ALIGN_CHECK_EN
        req(1'b0, 2'b10, 32'hFE, 32'hA1B2C3D4, 32'h56780000, 1'b0, 1'b0,
            "wr_wrap");
        chk("memFE", 33'(dut.mem[8'hFE]), 33'hA1);
        chk("memFF", 33'(dut.mem[8'hFF]), 33'hB2);
        chk("mem00", 33'(dut.mem[0]), 33'hC3);
        chk("mem01", 33'(dut.mem[1]), 33'hD4);
        req(1'b1, 2'b10, 32'hFE, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b0, "rd_wrap");
`endif

        req(1'b1, 2'b00, 32'h3, 32'h0, 32'h000000EF, 1'b0, 1'b1, "rd_drop");

        @(negedge CLK);
        MOV = 1'b1;
        RW = 1'b0;
        typeData = 2'b00;
        Address = 32'h10;
        DataIn = 32'h77;
        @(posedge CLK);
        @(negedge CLK);
        MOV = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        moc_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (MOC) moc_seen = 1'b1;
        end
        chk("clr_moc", {32'h0, moc_seen}, 33'h0);
        chk("clr_mem10", 33'(dut.mem[8'h10]), 33'h00);
        chk("clr_dout", {align_act, DataOut}, 33'h0);
        req(1'b1, 2'b00, 32'h2, 32'h0, 32'h000000BE, 1'b0, 1'b0, "rd_after");

`ifndef MEM_ALIGN_CHECK_EN
        req(1'b1, 2'b11, 32'h0, 32'h0, 32'hC3D4BEEF, 1'b0, 1'b0, "rd_t11");
`else
        req(1'b1, 2'b11, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd_t11");
        req(1'b0, 2'b10, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "wr_mis");
        chk("mis_mem1", 33'(dut.mem[1]), 33'hAD);
        chk("mis_mem2", 33'(dut.mem[2]), 33'hBE);
        chk("mis_mem3", 33'(dut.mem[3]), 33'hEF);
        chk("mis_mem4", 33'(dut.mem[4]), 33'h56);
        req(1'b1, 2'b01, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0, "rd_mis");
        req(1'b1, 2'b10, 32'h4, 32'h0, 32'h56780000, 1'b0, 1'b0, "rd_al");
`endif

        repeat (3) @(negedge CLK);
        chk("sb_empty", 33'(exp_q.size()), 33'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous byte-addressed memory that answers the CPU's memory handshake: the control unit raises MOV with RW, typeData, address and write data, and this block returns MOC when the access is done. It replaces the zero-latency behavioural RAM on the datapath side of MAR/MDR, adding a real four-phase handshake, programmable wait states and big-endian byte, halfword and word accesses. Storage is a 256×8 array named `mem`. Benches preload `mem` hierarchically before reset is released.

## Interface
Parameters:
- WAIT_STATES, 2: extra cycles between request capture and MOC assertion; legal range 0–15.
- ADDR_W, 8: address bits used; depth is 2^ADDR_W bytes.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- MOV  in  1  memory operation valid, from the control unit.
- RW  in  1  1 = read, 0 = write.
- typeData  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- Address  in  32  byte address; only bits [ADDR_W-1:0] are used, upper bits are ignored.
- DataIn  in  32  write data, right-aligned.
- DataOut  out  32  read data, right-aligned and zero-extended.
- MOC  out  1  memory operation complete.
- ALIGN_ERR  out  1  present only with MEM_ALIGN_CHECK_EN.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - ACK: MOC held high.
- IDLE → WAIT on a rising edge with MOV=1.
  - That edge captures RW, typeData, Address[ADDR_W-1:0] and DataIn into internal registers.
  - The wait counter loads WAIT_STATES.
- WAIT:
  - The counter decrements on each edge while it is nonzero.
  - On the edge where the counter is 0, the state moves to ACK.
  - On that same edge the block performs the access using the captured values, sets MOC=1 and updates DataOut.
- ACK: MOC and DataOut are held until an edge samples MOV=0. That edge moves the state to IDLE and clears MOC.
- Byte ordering is big-endian. Let a be the captured address.
  - Byte: mem[a] ↔ DataIn[7:0] / DataOut[7:0].
  - Halfword: mem[a] ↔ [15:8], mem[a+1] ↔ [7:0].
  - Word: mem[a] ↔ [31:24], mem[a+1] ↔ [23:16], mem[a+2] ↔ [15:8], mem[a+3] ↔ [7:0].
  - a+n is computed modulo 2^ADDR_W, so accesses wrap from 255 to 0.
- Reads: DataOut bits above the access size are 0.
- Writes:
  - DataOut is left unchanged.
  - Only the addressed bytes are modified.
  - DataIn bits above the access size are ignored.
- MOV, RW, typeData, Address and DataIn are ignored outside the IDLE capture edge.
- A MOV drop during WAIT does not cancel the access. The access completes, MOC is high for exactly one cycle, and the state then returns to IDLE.

## Timing
- Latency: request captured at edge E0; MOC rises after edge E0+WAIT_STATES+1. With WAIT_STATES=0, MOC rises after E0+1.
- Write data is visible in `mem` after the same edge that raises MOC.
- MOC falls after the first edge that samples MOV=0 in ACK.
- A new request is accepted at the earliest on the next edge that sees MOV=1 in IDLE. Minimum request spacing is WAIT_STATES+3 cycles.
- Reset values:
  - state IDLE;
  - MOC=0;
  - DataOut=0;
  - wait counter 0;
  - ALIGN_ERR=0.
- `mem` is never cleared by reset.
- CLR asserted in WAIT aborts the access and suppresses the pending write. CLR asserted in ACK leaves `mem` as already written.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A halfword access with a[0]≠0 is misaligned.
  - A word access (typeData 10 or 11) with a[1:0]≠00 is misaligned.
  - On a misaligned access the handshake completes normally, but no write occurs and DataOut is set to 0.
  - ALIGN_ERR is 1 while MOC is 1 and is cleared when MOC clears.
- MEM_ALIGN_CHECK_EN undefined:
  - The ALIGN_ERR port does not exist.
  - Misaligned accesses proceed with modulo wrap-around as described in Operation.

## Test plan
- Word read, WAIT_STATES=2: preload mem[0..3]=DE,AD,BE,EF; read word @0. Required: MOC rises 3 edges after capture; DataOut=DEADBEEF; MOC falls one edge after MOV drops.
- Byte and halfword reads, same preload:
  - byte @2 → DataOut=000000BE.
  - halfword @2 → DataOut=0000BEEF.
- Partial write: write halfword DataIn=12345678 @4 over mem[4..7]=00, then read word @4. Required: DataOut=56780000; mem[6], mem[7] unchanged.
- Wrap-around, macro undefined: write word DataIn=A1B2C3D4 @FE. Required: mem[FE]=A1, mem[FF]=B2, mem[00]=C3, mem[01]=D4.
- Reset mid-operation: CLR pulsed during WAIT of a byte write 77 @10 (mem[10]=00). Required: MOC stays 0; mem[10]=00; DataOut=0; the next request completes normally.
- Alignment, macro defined: word write @01 with DataIn=FFFFFFFF. Required: ALIGN_ERR=1 with MOC; mem[01..04] unchanged; DataOut=0.
